// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS-I decode stage: IF/ID latch, register file, forwarding, hazards, branch resolve, ID/EX latch
module decode_stage #(
    parameter int DW        = 32,
    parameter bit FWD_EN    = 1'b1,
    parameter bit RF_BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [31:0]   i_instr,
    input  logic [DW-1:0] i_pc,
    input  logic          i_wb_we,
    input  logic [4:0]    i_wb_addr,
    input  logic [DW-1:0] i_wb_data,
    input  logic          i_e_we,
    input  logic          i_e_load,
    input  logic [4:0]    i_e_addr,
    input  logic [DW-1:0] i_e_data,
    input  logic          i_m_we,
    input  logic          i_m_load,
    input  logic [4:0]    i_m_addr,
    input  logic [DW-1:0] i_m_data,
    output logic          o_stall,
    output logic          o_br_taken,
    output logic [DW-1:0] o_br_target,
    output logic          o_valid,
    output logic          o_we,
    output logic          o_load,
    output logic          o_store,
    output logic [5:0]    o_op,
    output logic [5:0]    o_funct,
    output logic [DW-1:0] o_rd1,
    output logic [DW-1:0] o_rd2,
    output logic [DW-1:0] o_imm,
    output logic [4:0]    o_wra
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic          valid;
        logic          we;
        logic          load;
        logic          store;
        logic [5:0]    op;
        logic [5:0]    funct;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [4:0]    wra;
    } idex_t;

    logic          ifid_valid_q, ifid_valid_d;
    logic [31:0]   ifid_instr_q, ifid_instr_d;
    logic [DW-1:0] ifid_pc_q, ifid_pc_d;
    logic [DW-1:0] rf_q [32];
    idex_t         idex_q, idex_d;

    logic [5:0]    op;
    logic [4:0]    rs, rt, rd;
    logic [15:0]   imm16;
    logic [DW-1:0] pc4, sext_imm, zext_imm;
    logic          use_rs, use_rt, is_br, is_jump;
    logic          dec_we, dec_load, dec_store;
    logic [4:0]    dec_wra;
    logic [DW-1:0] dec_imm;
    logic [DW-1:0] opa, opb;
    logic          e_hit, m_hit, hazard, br_cond;
    logic          stall, br_taken;

    assign op       = ifid_instr_q[31:26];
    assign rs       = ifid_instr_q[25:21];
    assign rt       = ifid_instr_q[20:16];
    assign rd       = ifid_instr_q[15:11];
    assign imm16    = ifid_instr_q[15:0];
    assign pc4      = ifid_pc_q + DW'(4);
    assign sext_imm = {{(DW-16){imm16[15]}}, imm16};
    assign zext_imm = {{(DW-16){1'b0}}, imm16};

    always_comb begin
        use_rs    = 1'b0;
        use_rt    = 1'b0;
        is_br     = 1'b0;
        is_jump   = 1'b0;
        dec_we    = 1'b0;
        dec_load  = 1'b0;
        dec_store = 1'b0;
        dec_wra   = 5'd0;
        dec_imm   = '0;
        case (op)
            OP_RTYPE: begin
                use_rs  = 1'b1;
                use_rt  = 1'b1;
                dec_we  = 1'b1;
                dec_wra = rd;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI: begin
                use_rs  = 1'b1;
                dec_we  = 1'b1;
                dec_wra = rt;
                dec_imm = sext_imm;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                use_rs  = 1'b1;
                dec_we  = 1'b1;
                dec_wra = rt;
                dec_imm = zext_imm;
            end
            OP_LUI: begin
                dec_we  = 1'b1;
                dec_wra = rt;
                dec_imm = DW'({imm16, 16'h0000});
            end
            OP_LW: begin
                use_rs   = 1'b1;
                dec_we   = 1'b1;
                dec_load = 1'b1;
                dec_wra  = rt;
                dec_imm  = sext_imm;
            end
            OP_SW: begin
                use_rs    = 1'b1;
                use_rt    = 1'b1;
                dec_store = 1'b1;
                dec_imm   = sext_imm;
            end
            OP_BEQ, OP_BNE: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                is_br  = 1'b1;
            end
            OP_J: begin
                is_jump = 1'b1;
            end
            OP_JAL: begin
                is_jump = 1'b1;
                dec_we  = 1'b1;
                dec_wra = 5'd31;
                dec_imm = ifid_pc_q + DW'(8);
            end
            default: ;
        endcase
        // A write to r0 is architecturally a no-op, so it never claims a destination
        if (dec_wra == 5'd0) dec_we = 1'b0;
    end

    function automatic logic [DW-1:0] operand(input logic [4:0] a);
        logic [DW-1:0] v;
        v = rf_q[a];
        if (RF_BYPASS && i_wb_we && i_wb_addr == a) v = i_wb_data;
        if (FWD_EN) begin
            if (i_m_we && i_m_addr == a) v = i_m_data;
            if (i_e_we && !i_e_load && i_e_addr == a) v = i_e_data;
        end
        if (a == 5'd0) v = '0;
        return v;
    endfunction

    assign opa = operand(rs);
    assign opb = operand(rt);

    assign e_hit = (i_e_addr != 5'd0) && ((use_rs && i_e_addr == rs) || (use_rt && i_e_addr == rt));
    assign m_hit = (i_m_addr != 5'd0) && ((use_rs && i_m_addr == rs) || (use_rt && i_m_addr == rt));

    // Branches compare in decode, so with forwarding they still wait on any E result and on M loads
    assign hazard = FWD_EN ? ((i_e_we && i_e_load && e_hit) ||
                              (is_br && i_e_we && e_hit) ||
                              (is_br && i_m_we && i_m_load && m_hit))
                           : ((i_e_we && e_hit) || (i_m_we && m_hit));

    assign stall   = ifid_valid_q && hazard;
    assign br_cond = is_jump || (op == OP_BEQ && opa == opb) || (op == OP_BNE && opa != opb);
    assign br_taken = ifid_valid_q && !stall && br_cond;

    assign o_stall     = stall;
    assign o_br_taken  = br_taken;
    assign o_br_target = !br_taken ? '0 :
                         is_jump   ? {pc4[DW-1:28], ifid_instr_q[25:0], 2'b00} :
                                     pc4 + {sext_imm[DW-3:0], 2'b00};

    always_comb begin
        ifid_valid_d = i_valid;
        ifid_instr_d = i_instr;
        ifid_pc_d    = i_pc;
        if (stall) begin
            ifid_valid_d = ifid_valid_q;
            ifid_instr_d = ifid_instr_q;
            ifid_pc_d    = ifid_pc_q;
        end else if (br_taken) begin
            ifid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (i_wb_we && i_wb_addr != 5'd0) begin
            rf_q[i_wb_addr] <= i_wb_data;
        end
    end

    always_comb begin
        idex_d = '0;
        if (ifid_valid_q && !stall) begin
            idex_d.valid = 1'b1;
            idex_d.we    = dec_we;
            idex_d.load  = dec_load;
            idex_d.store = dec_store;
            idex_d.op    = op;
            idex_d.funct = ifid_instr_q[5:0];
            idex_d.rd1   = opa;
            idex_d.rd2   = opb;
            idex_d.imm   = dec_imm;
            idex_d.wra   = dec_wra;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) idex_q <= '0;
        else      idex_q <= idex_d;
    end

    assign o_valid = idex_q.valid;
    assign o_we    = idex_q.we;
    assign o_load  = idex_q.load;
    assign o_store = idex_q.store;
    assign o_op    = idex_q.op;
    assign o_funct = idex_q.funct;
    assign o_rd1   = idex_q.rd1;
    assign o_rd2   = idex_q.rd2;
    assign o_imm   = idex_q.imm;
    assign o_wra   = idex_q.wra;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - random and directed checks of decode_stage (forwarding and stall-only builds) against a reference model
module tb_decode_stage;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          i_valid;
    logic [31:0]   i_instr;
    logic [DW-1:0] i_pc;
    logic          i_wb_we, i_e_we, i_e_load, i_m_we, i_m_load;
    logic [4:0]    i_wb_addr, i_e_addr, i_m_addr;
    logic [DW-1:0] i_wb_data, i_e_data, i_m_data;

    logic          o_stall [2], o_br_taken [2], o_valid [2], o_we [2], o_load [2], o_store [2];
    logic [DW-1:0] o_br_target [2], o_rd1 [2], o_rd2 [2], o_imm [2];
    logic [5:0]    o_op [2], o_funct [2];
    logic [4:0]    o_wra [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        decode_stage #(.DW(DW), .FWD_EN(g == 0), .RF_BYPASS(1'b1)) dut (
            .clk(clk), .rst(rst), .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc),
            .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
            .i_e_we(i_e_we), .i_e_load(i_e_load), .i_e_addr(i_e_addr), .i_e_data(i_e_data),
            .i_m_we(i_m_we), .i_m_load(i_m_load), .i_m_addr(i_m_addr), .i_m_data(i_m_data),
            .o_stall(o_stall[g]), .o_br_taken(o_br_taken[g]), .o_br_target(o_br_target[g]),
            .o_valid(o_valid[g]), .o_we(o_we[g]), .o_load(o_load[g]), .o_store(o_store[g]),
            .o_op(o_op[g]), .o_funct(o_funct[g]), .o_rd1(o_rd1[g]), .o_rd2(o_rd2[g]),
            .o_imm(o_imm[g]), .o_wra(o_wra[g])
        );
    end

    typedef struct packed {
        logic          valid, we, load, store;
        logic [5:0]    op, funct;
        logic [DW-1:0] rd1, rd2, imm;
        logic [4:0]    wra;
    } idex_t;

    typedef struct packed {
        logic          use_rs, use_rt, we, load, store, br, jmp;
        logic [4:0]    wra;
        logic [DW-1:0] imm;
    } dec_t;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: index 0 is the forwarding build, index 1 the stall-only build
    bit            mv [2];
    logic [31:0]   mi [2];
    logic [DW-1:0] mp [2];
    idex_t         exp_q [2];
    logic [DW-1:0] mrf [32];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic dec_t decode(input logic [31:0] ins, input logic [DW-1:0] pc);
        dec_t d;
        logic [5:0] op;
        op = ins[31:26];
        d = '0;
        d.br     = op inside {6'h04, 6'h05};
        d.jmp    = op inside {6'h02, 6'h03};
        d.use_rs = op inside {6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05};
        d.use_rt = op inside {6'h00, 6'h2B, 6'h04, 6'h05};
        if (op == 6'h00) d.wra = ins[15:11];
        else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23}) d.wra = ins[20:16];
        else if (op == 6'h03) d.wra = 5'd31;
        d.we    = (d.wra != 5'd0);
        d.load  = (op == 6'h23);
        d.store = (op == 6'h2B);
        if (op inside {6'h08, 6'h09, 6'h0A, 6'h23, 6'h2B}) d.imm = 32'($signed(ins[15:0]));
        else if (op inside {6'h0C, 6'h0D, 6'h0E}) d.imm = 32'(ins[15:0]);
        else if (op == 6'h0F) d.imm = 32'(ins[15:0]) * 65536;
        else if (op == 6'h03) d.imm = pc + 8;
        return d;
    endfunction

    function automatic logic [DW-1:0] opnd(input logic [4:0] r, input int k);
        if (r == 5'd0) return '0;
        if (k == 0 && i_e_we && !i_e_load && i_e_addr == r) return i_e_data;
        if (k == 0 && i_m_we && i_m_addr == r) return i_m_data;
        if (i_wb_we && i_wb_addr == r) return i_wb_data;
        return mrf[r];
    endfunction

    function automatic bit hit(input logic [4:0] a, input dec_t d, input logic [4:0] rs, input logic [4:0] rt);
        return (a != 5'd0) && ((d.use_rs && a == rs) || (d.use_rt && a == rt));
    endfunction

    task automatic model_comb(input int k, output bit stall, output bit taken,
                              output logic [DW-1:0] tgt, output idex_t nxt);
        dec_t d;
        logic [4:0] rs, rt;
        logic [DW-1:0] a, b, pc4;
        bit eh, mh, hz, cond;
        d  = decode(mi[k], mp[k]);
        rs = mi[k][25:21];
        rt = mi[k][20:16];
        a  = opnd(rs, k);
        b  = opnd(rt, k);
        eh = hit(i_e_addr, d, rs, rt);
        mh = hit(i_m_addr, d, rs, rt);
        if (k == 0) hz = (i_e_we && i_e_load && eh) || (d.br && i_e_we && eh) || (d.br && i_m_we && i_m_load && mh);
        else        hz = (i_e_we && eh) || (i_m_we && mh);
        stall = mv[k] && hz;
        cond  = d.jmp || (mi[k][31:26] == 6'h04 && a == b) || (mi[k][31:26] == 6'h05 && a != b);
        taken = mv[k] && !stall && cond;
        pc4   = mp[k] + 4;
        if (d.jmp) tgt = (pc4 & 32'hF000_0000) | (32'(mi[k][25:0]) * 4);
        else       tgt = pc4 + (32'($signed(mi[k][15:0])) << 2);
        if (mv[k] && !stall) nxt = {1'b1, d.we, d.load, d.store, mi[k][31:26], mi[k][5:0], a, b, d.imm, d.wra};
        else nxt = '0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mv[k] = 0; mi[k] = '0; mp[k] = '0; exp_q[k] = '0;
        end
        for (int r = 0; r < 32; r++) mrf[r] = '0;
    endtask

    task automatic model_compare();
        bit st, tk;
        logic [DW-1:0] tg;
        idex_t nx, act;
        for (int k = 0; k < 2; k++) begin
            model_comb(k, st, tk, tg, nx);
            act = {o_valid[k], o_we[k], o_load[k], o_store[k], o_op[k], o_funct[k],
                   o_rd1[k], o_rd2[k], o_imm[k], o_wra[k]};
            chk($sformatf("stall[%0d]", k), o_stall[k], st);
            chk($sformatf("br_taken[%0d]", k), o_br_taken[k], tk);
            if (!rst || tk) chk($sformatf("br_target[%0d]", k), o_br_target[k], tk ? tg : '0);
            chk($sformatf("idex[%0d]", k), act, exp_q[k]);
        end
    endtask

    task automatic model_next();
        bit st, tk;
        logic [DW-1:0] tg;
        idex_t nx;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            model_comb(k, st, tk, tg, nx);
            exp_q[k] = nx;
            if (!st) begin
                mv[k] = tk ? 1'b0 : i_valid;
                mi[k] = i_instr;
                mp[k] = i_pc;
            end
        end
        if (i_wb_we && i_wb_addr != 5'd0) mrf[i_wb_addr] = i_wb_data;
    endtask

    task automatic settle();  @(negedge clk); model_compare(); endtask
    task automatic advance(); model_next(); @(posedge clk); #1; endtask
    task automatic tick();    settle(); advance(); endtask

    task automatic idle();
        i_valid = 0; i_instr = '0; i_pc = '0;
        i_wb_we = 0; i_wb_addr = '0; i_wb_data = '0;
        i_e_we = 0; i_e_load = 0; i_e_addr = '0; i_e_data = '0;
        i_m_we = 0; i_m_load = 0; i_m_addr = '0; i_m_data = '0;
    endtask

    task automatic fetch(input logic [31:0] ins, input logic [DW-1:0] pc);
        idle(); i_valid = 1; i_instr = ins; i_pc = pc;
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [16] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h20, 6'h3F};
        return {ops[$urandom_range(0, 15)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 11'($urandom)};
    endfunction

    task automatic rand_inputs();
        i_valid   = ($urandom_range(0, 3) != 0);
        i_instr   = rand_instr();
        i_pc      = $urandom & 32'hFFFF_FFFC;
        i_wb_we   = 1'($urandom_range(0, 1));
        i_wb_addr = 5'($urandom_range(0, 7));
        i_wb_data = $urandom;
        i_e_we    = 1'($urandom_range(0, 1));
        i_e_load  = ($urandom_range(0, 3) == 0);
        i_e_addr  = 5'($urandom_range(0, 7));
        i_e_data  = $urandom;
        i_m_we    = 1'($urandom_range(0, 1));
        i_m_load  = ($urandom_range(0, 3) == 0);
        i_m_addr  = 5'($urandom_range(0, 7));
        i_m_data  = $urandom;
    endtask

    initial begin
        rst = 0;
        idle();
        model_reset();
        @(posedge clk); #1;
        settle();
        chk("reset_valid", o_valid[0], 1'b0);
        chk("reset_stall", o_stall[1], 1'b0);
        advance();
        rst = 1;
        tick();

        // Writeback bypass into a same-cycle read
        fetch(rtype(5, 0, 3), 32'h10); tick();
        idle(); i_wb_we = 1; i_wb_addr = 5; i_wb_data = 32'h1234; tick();
        chk("wb_bypass0", o_rd1[0], 32'h1234);
        chk("wb_bypass1", o_rd1[1], 32'h1234);
        idle(); tick(); tick();

        // Load-use: one stall, bubble, then operand from M
        fetch(rtype(2, 2, 4), 32'h200); tick();
        idle(); i_e_we = 1; i_e_load = 1; i_e_addr = 2; i_e_data = 32'hDEAD;
        settle(); chk("lu_stall", o_stall[0], 1'b1); advance();
        chk("lu_bubble", o_valid[0], 1'b0);
        idle(); i_m_we = 1; i_m_load = 1; i_m_addr = 2; i_m_data = 32'hBEEF;
        settle(); chk("lu_release", o_stall[0], 1'b0); advance();
        chk("lu_fwd", o_rd1[0], 32'hBEEF);
        chk("lu_valid", o_valid[0], 1'b1);
        idle(); tick(); tick(); tick();

        // Asynchronous reset while a load-use pair is stalled
        fetch(rtype(2, 2, 4), 32'h200); tick();
        idle(); i_e_we = 1; i_e_load = 1; i_e_addr = 2;
        settle(); chk("rst_pre_stall", o_stall[0], 1'b1);
        rst = 0; #1; model_reset();
        for (int k = 0; k < 2; k++)
            chk($sformatf("rst_outputs[%0d]", k),
                {o_stall[k], o_br_taken[k], o_br_target[k], o_valid[k], o_we[k], o_load[k], o_store[k],
                 o_op[k], o_funct[k], o_rd1[k], o_rd2[k], o_imm[k], o_wra[k]}, '0);
        advance();
        rst = 1;
        fetch(rtype(5, 0, 3), 32'h20); tick();
        idle(); tick();
        chk("rst_rf_cleared", o_rd1[0], 32'h0);
        tick();

        // beq r1,r1,-1 at 0x100 branches to itself and squashes the next fetch
        fetch({6'h04, 5'd1, 5'd1, 16'hFFFF}, 32'h100); tick();
        fetch(rtype(5, 0, 3), 32'h104);
        settle(); chk("beq_taken", o_br_taken[0], 1'b1); chk("beq_target", o_br_target[0], 32'h100); advance();
        idle(); settle(); chk("beq_squash_nobr", o_br_taken[0], 1'b0); advance();
        chk("beq_squash", o_valid[0], 1'b0);
        tick();

        // jal at 0x400 to index 0x40
        fetch({6'h03, 26'h40}, 32'h400); tick();
        idle(); settle(); chk("jal_taken", o_br_taken[0], 1'b1); chk("jal_target", o_br_target[0], 32'h100); advance();
        chk("jal_wra", o_wra[0], 5'd31);
        chk("jal_imm", o_imm[0], 32'h408);
        chk("jal_we", o_we[0], 1'b1);
        tick();

        // E beats M on r7; stall-only build waits until neither stage matches
        fetch(rtype(7, 0, 1), 32'h300); tick();
        idle(); i_e_we = 1; i_e_addr = 7; i_e_data = 32'hA; i_m_we = 1; i_m_addr = 7; i_m_data = 32'hB;
        settle(); chk("prio_nostall", o_stall[0], 1'b0); chk("nofwd_stall_em", o_stall[1], 1'b1); advance();
        chk("prio_e_wins", o_rd1[0], 32'hA);
        idle(); i_m_we = 1; i_m_addr = 7; i_m_data = 32'hA;
        settle(); chk("nofwd_stall_m", o_stall[1], 1'b1); advance();
        idle(); i_wb_we = 1; i_wb_addr = 7; i_wb_data = 32'hA;
        settle(); chk("nofwd_release", o_stall[1], 1'b0); advance();
        chk("nofwd_rd1", o_rd1[1], 32'hA);
        idle(); tick(); tick();

        for (int c = 0; c < 4000; c++) begin
            rand_inputs();
            if (!rst) rst = 1;
            else if ($urandom_range(0, 299) == 0) begin
                rst = 0; #1; model_reset();
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
